// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED power sequencer.
// INIT_ROM is the panel command stream sent before VBAT is enabled.
package oled_pkg;

    typedef enum logic [3:0] {
        S_OFF      = 4'd0,
        S_VDD      = 4'd1,
        S_RES      = 4'd2,
        S_RES_REL  = 4'd3,
        S_INIT     = 4'd4,
        S_VBAT     = 4'd5,
        S_DISP_ON  = 4'd6,
        S_READY    = 4'd7,
        S_DISP_OFF = 4'd8,
        S_VBAT_OFF = 4'd9,
        S_VDD_OFF  = 4'd10
    } state_t;

    localparam logic [7:0] OLED_CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] OLED_CMD_DISPLAY_OFF = 8'hAE;

    localparam logic [3:0] INIT_LEN = 4'd11;

    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
        8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20
    };

    // A wait of N cycles loads N-1; zero is treated as one cycle.
    function automatic logic [31:0] delay_load(input logic [31:0] n);
        return (n == 32'd0) ? 32'd0 : n - 32'd1;
    endfunction

endpackage

// File: rtl/oled_delay_timer.sv
// Single shared down-counter for the sequencer's timed states.
// done is high whenever the count has reached zero.
module oled_delay_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] count,
    output logic        done
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = count;
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 32'd0);

endmodule

// File: rtl/oled_power_sequencer.sv
// OLED bring-up/shutdown sequencer; shares the SPI byte transmitter
// between host commands (dc=0) and the pixel stream (dc=1).
module oled_power_sequencer
    import oled_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 20_000_000,
    parameter int unsigned VDD_CYCLES  = CLK_FREQ / 1000,
    parameter int unsigned RES_CYCLES  = CLK_FREQ / 200000,
    parameter int unsigned VBAT_CYCLES = CLK_FREQ / 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    input  logic       tx_ready,
    input  logic       tx_idle,
    output logic       oled_vdd,
    output logic       oled_vbat,
    output logic       oled_res,
    output logic       init_done
);

    localparam logic [31:0] VDD_LD  = delay_load(VDD_CYCLES);
    localparam logic [31:0] RES_LD  = delay_load(RES_CYCLES);
    localparam logic [31:0] VBAT_LD = delay_load(VBAT_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic        gnt_cmd_q;
    logic        gnt_pix_q;
    logic        stop_pend_q;
    logic        stop_pend_d;

    logic        gnt_cmd;
    logic        gnt_pix;
    logic        keep;
    logic        in_ready;
    logic        stop_req;
    logic        stop_take;
    logic        xfer;
    logic [7:0]  rom_byte;

    logic        t_load;
    logic [31:0] t_count;
    logic        t_done;

    oled_delay_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .count (t_count),
        .done  (t_done)
    );

    assign in_ready = (state_q == S_READY);
    assign stop_req = in_ready & (stop | stop_pend_q);
    assign rom_byte = (idx_q < INIT_LEN) ? INIT_ROM[idx_q] : 8'h00;

    // Owner keeps the grant while it has data or a byte is still shifting.
    assign keep = (gnt_cmd_q & (cmd_valid | ~tx_idle))
                | (gnt_pix_q & (pix_valid | ~tx_idle));

    always_comb begin
        gnt_cmd = 1'b0;
        gnt_pix = 1'b0;
        if (in_ready) begin
            if (keep) begin
                gnt_cmd = gnt_cmd_q;
                gnt_pix = gnt_pix_q;
            end else if (!stop_req) begin
                gnt_cmd = cmd_valid;
                gnt_pix = ~cmd_valid & pix_valid;
            end
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_dc    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                tx_valid = (idx_q != INIT_LEN);
                tx_data  = rom_byte;
            end
            S_DISP_ON: begin
                tx_valid = (idx_q == 4'd0);
                tx_data  = OLED_CMD_DISPLAY_ON;
            end
            S_DISP_OFF: begin
                tx_valid = (idx_q == 4'd0);
                tx_data  = OLED_CMD_DISPLAY_OFF;
            end
            S_READY: begin
                tx_valid = (gnt_cmd & cmd_valid) | (gnt_pix & pix_valid);
                tx_data  = gnt_pix ? pix_data : (gnt_cmd ? cmd_data : 8'h00);
                tx_dc    = gnt_pix;
            end
            default: ;
        endcase
    end

    assign xfer      = tx_valid & tx_ready;
    assign stop_take = stop_req & (~tx_valid | tx_ready);

    always_comb begin
        state_d = state_q;
        t_load  = 1'b0;
        t_count = 32'd0;
        unique case (state_q)
            S_OFF: if (start) begin
                state_d = S_VDD;
                t_load  = 1'b1;
                t_count = VDD_LD;
            end
            S_VDD: if (t_done) begin
                state_d = S_RES;
                t_load  = 1'b1;
                t_count = RES_LD;
            end
            S_RES: if (t_done) begin
                state_d = S_RES_REL;
                t_load  = 1'b1;
                t_count = VDD_LD;
            end
            S_RES_REL: if (t_done) state_d = S_INIT;
            S_INIT: if (idx_q == INIT_LEN && tx_idle) begin
                state_d = S_VBAT;
                t_load  = 1'b1;
                t_count = VBAT_LD;
            end
            S_VBAT: if (t_done) state_d = S_DISP_ON;
            S_DISP_ON: if (idx_q != 4'd0 && tx_idle) state_d = S_READY;
            S_READY: if (stop_take) state_d = S_DISP_OFF;
            S_DISP_OFF: if (idx_q != 4'd0 && tx_idle) begin
                state_d = S_VBAT_OFF;
                t_load  = 1'b1;
                t_count = VBAT_LD;
            end
            S_VBAT_OFF: if (t_done) state_d = S_VDD_OFF;
            S_VDD_OFF: state_d = S_OFF;
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (state_d != state_q) begin
            idx_d = 4'd0;
        end else if (xfer && !in_ready) begin
            idx_d = idx_q + 4'd1;
        end
    end

    assign stop_pend_d = stop_req & ~stop_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_OFF;
            idx_q       <= '0;
            gnt_cmd_q   <= 1'b0;
            gnt_pix_q   <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gnt_cmd_q   <= gnt_cmd & ~stop_take;
            gnt_pix_q   <= gnt_pix & ~stop_take;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign cmd_ready = tx_ready & gnt_cmd & in_ready;
    assign pix_ready = tx_ready & gnt_pix & in_ready;
    assign init_done = in_ready;
    assign oled_vdd  = (state_q != S_OFF) && (state_q != S_VDD_OFF);
    assign oled_res  = state_q inside {S_RES_REL, S_INIT, S_VBAT, S_DISP_ON,
                                       S_READY, S_DISP_OFF, S_VBAT_OFF};
    assign oled_vbat = state_q inside {S_VBAT, S_DISP_ON, S_READY, S_DISP_OFF};

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Randomized bench for oled_power_sequencer: byte-stream scoreboard,
// rail timing measured from pin edges, and a 3-cycle-latency SPI model.
module tb_oled_power_sequencer;

    localparam int VDD  = 4;
    localparam int RES  = 2;
    localparam int VBAT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_ready;
    logic       tx_idle;
    logic       oled_vdd;
    logic       oled_vbat;
    logic       oled_res;
    logic       init_done;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] rom_exp [11] = '{
        8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
        8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20
    };

    always #5 clk = ~clk;

    oled_power_sequencer #(
        .VDD_CYCLES  (VDD),
        .RES_CYCLES  (RES),
        .VBAT_CYCLES (VBAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_dc     (tx_dc),
        .tx_ready  (tx_ready),
        .tx_idle   (tx_idle),
        .oled_vdd  (oled_vdd),
        .oled_vbat (oled_vbat),
        .oled_res  (oled_res),
        .init_done (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Source queues and observed/expected {dc,data} streams
    logic [7:0] cmd_q [$];
    logic [7:0] pix_q [$];
    logic [8:0] obs [$];
    logic [8:0] exp [$];

    logic cmd_acc = 1'b0;
    logic pix_acc = 1'b0;
    logic xfer_s  = 1'b0;
    logic vld_s   = 1'b0;

    int cyc = 0;
    int t_vdd_up = 0, t_vdd_dn = 0, t_res_up = 0, t_res_dn = 0;
    int t_vbat_up = 0, t_vbat_dn = 0, t_tx1 = 0, t_af = 0;
    int hold_err = 0, glitch = 0, vld_cnt = 0;
    logic arm_tx = 1'b0, arm_af = 1'b0;
    logic p_vdd = 1'b0, p_res = 1'b0, p_vbat = 1'b0;
    logic p_vld = 1'b0, p_rdy = 1'b0, p_dc = 1'b0, p_rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic last_dc = 1'b0, idle_seen = 1'b1;

    // Monitor: samples on the falling edge, away from the active edge
    initial forever begin
        @(negedge clk);
        cyc++;
        cmd_acc = cmd_valid & cmd_ready;
        pix_acc = pix_valid & pix_ready;
        xfer_s  = tx_valid & tx_ready;
        vld_s   = tx_valid;
        if (tx_valid) vld_cnt++;
        if (!reset && !p_rst && p_vld && !p_rdy &&
            (!tx_valid || tx_data !== p_data || tx_dc !== p_dc))
            hold_err++;
        if (tx_idle) idle_seen = 1'b1;
        if (xfer_s) begin
            obs.push_back({tx_dc, tx_data});
            if (tx_dc != last_dc && !idle_seen) glitch++;
            last_dc   = tx_dc;
            idle_seen = 1'b0;
        end
        if (oled_vdd && !p_vdd) t_vdd_up = cyc;
        if (!oled_vdd && p_vdd) t_vdd_dn = cyc;
        if (oled_res && !p_res) begin t_res_up = cyc; arm_tx = 1'b1; end
        if (!oled_res && p_res) t_res_dn = cyc;
        if (oled_vbat && !p_vbat) begin t_vbat_up = cyc; arm_af = 1'b1; end
        if (!oled_vbat && p_vbat) t_vbat_dn = cyc;
        if (tx_valid && arm_tx) begin t_tx1 = cyc; arm_tx = 1'b0; end
        if (tx_valid && arm_af) begin t_af = cyc; arm_af = 1'b0; end
        p_vdd  = oled_vdd;
        p_res  = oled_res;
        p_vbat = oled_vbat;
        p_vld  = tx_valid;
        p_rdy  = tx_ready;
        p_dc   = tx_dc;
        p_data = tx_data;
        p_rst  = reset;
    end

    // Transmitter model (ready after 3 valid cycles, 4-cycle shift) and sources
    int busy = 0;
    int lat  = 0;
    initial begin
        tx_ready  = 1'b0;
        tx_idle   = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (xfer_s) begin
                busy = 4;
                lat  = 0;
            end else begin
                if (busy > 0) busy--;
                if (vld_s) lat++;
            end
            tx_ready = (lat >= 3);
            tx_idle  = (busy == 0);
            if (cmd_acc && cmd_q.size() > 0) void'(cmd_q.pop_front());
            if (pix_acc && pix_q.size() > 0) void'(pix_q.pop_front());
            cmd_valid = (cmd_q.size() > 0);
            cmd_data  = cmd_valid ? cmd_q[0] : 8'h00;
            pix_valid = (pix_q.size() > 0);
            pix_data  = pix_valid ? pix_q[0] : 8'h00;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF,
                32'(exp[i]));
        end
        obs.delete();
        exp.delete();
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            ok = (cmd_q.size() == 0) && (pix_q.size() == 0) &&
                 tx_idle && !tx_valid;
        end
        repeat (2) @(posedge clk);
        chk({tag, "_drain"}, 32'(ok), 32'd1);
    endtask

    task automatic bringup(input string tag, input bit poke_stop);
        obs.delete();
        exp.delete();
        for (int i = 0; i < 11; i++) exp.push_back({1'b0, rom_exp[i]});
        exp.push_back({1'b0, 8'hAF});
        pulse_start();
        if (poke_stop) begin
            for (int i = 0; i < 400 && obs.size() < 3; i++) @(posedge clk);
            chk({tag, "_mid"}, 32'(init_done), 32'd0);
            pulse_stop();
        end
        for (int i = 0; i < 2000 && !init_done; i++) @(posedge clk);
        #1;
        chk({tag, "_ready"}, 32'(init_done), 32'd1);
        chk({tag, "_rails"}, {oled_vdd, oled_vbat, oled_res}, 32'b111);
        chk({tag, "_vdd2res"}, t_res_up - t_vdd_up, VDD + RES);
        chk({tag, "_res2tx"}, t_tx1 - t_res_up, VDD);
        chk({tag, "_vbat2af"}, t_af - t_vbat_up, VBAT);
        cmp_stream(tag);
    endtask

    task automatic power_down(input string tag);
        obs.delete();
        exp.delete();
        exp.push_back({1'b0, 8'hAE});
        pulse_stop();
        for (int i = 0; i < 500 && oled_vdd; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_off"},
            {oled_vdd, oled_vbat, oled_res, init_done, tx_valid}, 32'd0);
        chk({tag, "_vbat2vdd"}, t_vdd_dn - t_vbat_dn, VBAT);
        chk({tag, "_res_vdd"}, t_res_dn - t_vdd_dn, 0);
        cmp_stream(tag);
    endtask

    task automatic priority_test();
        int nc, np;
        logic [7:0] d;
        nc = $urandom_range(2, 5);
        np = $urandom_range(2, 6);
        for (int i = 0; i < nc; i++) begin
            d = 8'($urandom);
            cmd_q.push_back(d);
            exp.push_back({1'b0, d});
        end
        for (int i = 0; i < np; i++) begin
            d = 8'($urandom);
            pix_q.push_back(d);
            exp.push_back({1'b1, d});
        end
        drain("prio");
        cmp_stream("prio");
    endtask

    task automatic sticky_test();
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            d = 8'(i);
            pix_q.push_back(d);
            exp.push_back({1'b1, d});
        end
        for (int i = 0; i < 500 && obs.size() < 4; i++) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            cmd_q.push_back(d);
            exp.push_back({1'b0, d});
        end
        drain("sticky");
        cmp_stream("sticky");
    endtask

    task automatic random_rounds();
        int kind, nc, np;
        logic [7:0] d;
        for (int r = 0; r < 8; r++) begin
            kind = $urandom_range(0, 2);
            nc   = $urandom_range(1, 5);
            np   = $urandom_range(1, 5);
            if (kind != 1) begin
                for (int i = 0; i < nc; i++) begin
                    d = 8'($urandom);
                    cmd_q.push_back(d);
                    exp.push_back({1'b0, d});
                end
            end
            if (kind != 0) begin
                for (int i = 0; i < np; i++) begin
                    d = 8'($urandom);
                    pix_q.push_back(d);
                    exp.push_back({1'b1, d});
                end
            end
            drain($sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        cmp_stream("rand");
    endtask

    task automatic reset_test();
        int v0;
        obs.delete();
        exp.delete();
        pulse_start();
        for (int i = 0; i < 400 && obs.size() < 5; i++) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_async",
            {oled_vdd, oled_vbat, oled_res, init_done, tx_valid,
             cmd_ready, pix_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) exp.push_back({1'b0, rom_exp[i]});
        cmp_stream("rst_bytes");
        v0 = vld_cnt;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_quiet", vld_cnt - v0, 0);
        chk("rst_off", {oled_vdd, oled_vbat, oled_res, init_done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #2;
        chk("reset_out",
            {oled_vdd, oled_vbat, oled_res, init_done, tx_valid,
             cmd_ready, pix_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);

        bringup("up1", 1'b0);
        priority_test();
        sticky_test();
        random_rounds();

        obs.delete();
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        chk("start_ign", {init_done, oled_vdd, oled_vbat}, 32'b111);
        chk("start_ign_tx", obs.size(), 0);

        power_down("pd1");
        bringup("up2", 1'b1);
        priority_test();
        power_down("pd2");
        reset_test();
        bringup("up3", 1'b0);
        random_rounds();

        chk("hold_stable", hold_err, 0);
        chk("dc_glitch", glitch, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
